// File: rtl/alu_md.sv
// alu_md: single-issue ALU with a bit-serial multiplier and optional bit-serial divider.
// Define ALU_MD_DIV_EN to build the divider; without it, divu/div complete at once with zeros.
module alu_md #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       ctrl,
  input  logic [WIDTH-1:0] in_0,
  input  logic [WIDTH-1:0] in_1,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH + 1);
`ifdef ALU_MD_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_q;
  logic             r_neg_q;
`ifdef ALU_MD_DIV_EN
  logic             r_neg_r;
  logic             r_dz;
`endif

  function automatic logic [WIDTH-1:0] f_cneg(input logic [WIDTH-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  logic             w_is_mul;
  logic             w_is_div;
  logic             w_signed;
  logic             w_sa;
  logic             w_sb;
  logic [SHW-1:0]   w_sh;
  logic [WIDTH-1:0] w_alu;

  assign w_is_mul = (ctrl == 4'b0100) || (ctrl == 4'b1101);
  assign w_is_div = (ctrl == 4'b0101) || (ctrl == 4'b1110);
  assign w_signed = (ctrl == 4'b1101) || (ctrl == 4'b1110);
  assign w_sa     = w_signed & in_0[WIDTH-1];
  assign w_sb     = w_signed & in_1[WIDTH-1];
  assign w_sh     = in_0[SHW-1:0];

  assign in_ready = (r_state == S_IDLE);
  assign busy     = (r_state != S_IDLE);

  always_comb begin
    w_alu = '0;
    case (ctrl)
      4'b0000:          w_alu = in_0 & in_1;
      4'b0001:          w_alu = in_0 | in_1;
      4'b0010:          w_alu = in_0 + in_1;
      4'b0011, 4'b0110: w_alu = in_0 - in_1;
      4'b0111:          w_alu = {{(WIDTH-1){1'b0}}, $signed(in_0) < $signed(in_1)};
      4'b1000:          w_alu = ~(in_0 | in_1);
      4'b1001:          w_alu = in_0 ^ in_1;
      4'b1010:          w_alu = in_1 << w_sh;
      4'b1011:          w_alu = $unsigned($signed(in_1) >>> w_sh);
      4'b1100:          w_alu = in_1 >> w_sh;
      default:          w_alu = '0;
    endcase
  end

  // Multiply step: {r_rem, r_q} is the partial product / remaining multiplier bits.
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod;
  assign w_sum  = {1'b0, r_rem} + {1'b0, (r_q[0] ? r_m : {WIDTH{1'b0}})};
  assign w_prod = r_neg_q ? -{r_rem, r_q} : {r_rem, r_q};

`ifdef ALU_MD_DIV_EN
  // Restoring divide step: remainder shifts in one dividend bit per cycle.
  logic [WIDTH:0]   w_dsh;
  logic             w_ge;
  logic [WIDTH-1:0] w_dif;
  assign w_dsh = {r_rem, r_q[WIDTH-1]};
  assign w_ge  = w_dsh >= {1'b0, r_m};
  assign w_dif = w_dsh[WIDTH-1:0] - r_m;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_m       <= '0;
      r_rem     <= '0;
      r_q       <= '0;
      r_neg_q   <= 1'b0;
`ifdef ALU_MD_DIV_EN
      r_neg_r   <= 1'b0;
      r_dz      <= 1'b0;
`endif
      out_valid <= 1'b0;
      result    <= '0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      out_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            if (w_is_mul || (DIV_EN && w_is_div)) begin
              r_state <= w_is_mul ? S_MUL : S_DIV;
              r_cnt   <= '0;
              r_m     <= f_cneg(in_1, w_sb);
              r_q     <= f_cneg(in_0, w_sa);
              r_rem   <= '0;
              r_neg_q <= w_sa ^ w_sb;
`ifdef ALU_MD_DIV_EN
              r_neg_r <= w_sa;
              r_dz    <= (in_1 == '0);
`endif
            end else begin
              result    <= w_alu;
              out_valid <= 1'b1;
              if (w_is_div) begin
                hi <= '0;
                lo <= '0;
              end
            end
          end
        end
        S_MUL: begin
          if (r_cnt == CW'(WIDTH)) begin
            hi        <= w_prod[2*WIDTH-1:WIDTH];
            lo        <= w_prod[WIDTH-1:0];
            result    <= w_prod[WIDTH-1:0];
            out_valid <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_rem <= w_sum[WIDTH:1];
            r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DIV: begin
`ifdef ALU_MD_DIV_EN
          if (r_cnt == CW'(WIDTH)) begin
            lo        <= r_dz ? '1 : f_cneg(r_q, r_neg_q);
            result    <= r_dz ? '1 : f_cneg(r_q, r_neg_q);
            hi        <= f_cneg(r_rem, r_neg_r);
            out_valid <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_rem <= w_ge ? w_dif : w_dsh[WIDTH-1:0];
            r_q   <= {r_q[WIDTH-2:0], w_ge};
            r_cnt <= r_cnt + CW'(1);
          end
`else
          r_state <= S_IDLE;
`endif
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_md.sv
// tb_alu_md: directed corner cases plus randomized ops against an arithmetic reference model.
module tb_alu_md;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [3:0]   ctrl = 4'h0;
  logic [W-1:0] in_0 = '0;
  logic [W-1:0] in_1 = '0;
  logic         in_ready, out_valid, busy;
  logic [W-1:0] result, hi, lo;

  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  alu_md #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ctrl(ctrl), .in_0(in_0), .in_1(in_1), .out_valid(out_valid),
    .result(result), .hi(hi), .lo(lo), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic; updates the model's hi/lo when an op writes them.
  task automatic model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] res, output int lat);
    longint sa, sb, p;
    logic [63:0] up;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    lat = 0;
    res = '0;
    case (op)
      4'h0: res = a & b;
      4'h1: res = a | b;
      4'h2: res = a + b;
      4'h3, 4'h6: res = a - b;
      4'h7: res = (sa < sb) ? 32'd1 : 32'd0;
      4'h8: res = ~(a | b);
      4'h9: res = a ^ b;
      4'hA: res = b << a[4:0];
      4'hB: begin p = sb >>> a[4:0]; res = p[31:0]; end
      4'hC: res = b >> a[4:0];
      4'h4: begin
        up = {32'h0, a} * {32'h0, b};
        m_hi = up[63:32]; m_lo = up[31:0]; res = m_lo; lat = W + 1;
      end
      4'hD: begin
        p = sa * sb;
        m_hi = p[63:32]; m_lo = p[31:0]; res = m_lo; lat = W + 1;
      end
      4'h5, 4'hE: begin : div_model
`ifdef ALU_MD_DIV_EN
        longint q, r;
        lat = W + 1;
        if (b == '0) begin
          m_lo = '1; m_hi = a;
        end else if (op == 4'h5) begin
          m_lo = a / b; m_hi = a % b;
        end else begin
          q = sa / sb; r = sa % sb;
          m_lo = q[31:0]; m_hi = r[31:0];
        end
        res = m_lo;
`else
        m_hi = '0; m_lo = '0; res = '0;
`endif
      end
      default: res = '0;
    endcase
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit hold);
    logic [W-1:0] e_res;
    int e_lat, k;
    bit bad;
    model(op, a, b, e_res, e_lat);
    check({tag, ".ready"}, in_ready, 1);
    in_valid = 1'b1; ctrl = op; in_0 = a; in_1 = b;
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
    k = 0; bad = 1'b0;
    while (!out_valid && k < 3 * W) begin
      if (in_ready || !busy) bad = 1'b1;
      if (hold) begin in_0 = $urandom; in_1 = $urandom; end
      @(posedge clk); #1;
      k++;
    end
    in_valid = 1'b0;
    check({tag, ".latency"}, k, e_lat);
    if (e_lat > 0) check({tag, ".busy_window"}, bad, 0);
    check({tag, ".result"}, result, e_res);
    check({tag, ".hi"}, hi, m_hi);
    check({tag, ".lo"}, lo, m_lo);
    @(posedge clk); #1;
    check({tag, ".pulse_end"}, out_valid, 0);
    check({tag, ".idle"}, in_ready, 1);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return W'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit seen;
    logic [3:0] op;

    repeat (2) @(posedge clk);
    #1;
    check("rst.out_valid", out_valid, 0);
    check("rst.busy", busy, 0);
    check("rst.in_ready", in_ready, 1);
    check("rst.result", result, 0);
    check("rst.hi", hi, 0);
    check("rst.lo", lo, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op("add_ovf", 4'h2, 32'h7FFF_FFFF, 32'h1, 1'b0);
    check("add_ovf.lit", result, 32'h8000_0000);
    run_op("slt", 4'h7, 32'hFFFF_FFFF, 32'h1, 1'b0);
    check("slt.lit", result, 32'h1);
    run_op("sra", 4'hB, 32'd36, 32'h8000_0000, 1'b0);
    check("sra.lit", result, 32'hF800_0000);
    run_op("mult", 4'hD, 32'hFFFF_FFFD, 32'd7, 1'b0);
    check("mult.hi_lit", hi, 32'hFFFF_FFFF);
    check("mult.lo_lit", lo, 32'hFFFF_FFEB);
    run_op("code15", 4'hF, 32'h1234, 32'h5678, 1'b0);
    run_op("div", 4'hE, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("divu0", 4'h5, 32'd5, 32'd0, 1'b0);
    run_op("divovf", 4'hE, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("divs0", 4'hE, 32'hFFFF_FFF9, 32'd0, 1'b0);
`ifdef ALU_MD_DIV_EN
    run_op("div_lit", 4'hE, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div.lo_lit", lo, 32'hFFFF_FFFD);
    check("div.hi_lit", hi, 32'hFFFF_FFFF);
    run_op("divu0_lit", 4'h5, 32'd5, 32'd0, 1'b0);
    check("divu0.lo_lit", lo, 32'hFFFF_FFFF);
    check("divu0.hi_lit", hi, 32'd5);
`endif

    // Held request with changing operands while a multiply runs.
    run_op("mult_hold", 4'hD, 32'hFFFF_FF00, 32'h0001_2345, 1'b1);

    // Reset in the middle of a multu.
    in_valid = 1'b1; ctrl = 4'h4; in_0 = 32'hDEAD_BEEF; in_1 = 32'h0000_1234;
    @(posedge clk); #1;
    in_valid = 1'b0;
    seen = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    rst_n = 1'b0;
    #1;
    check("rst_mid.no_pulse", seen, 0);
    check("rst_mid.out_valid", out_valid, 0);
    check("rst_mid.busy", busy, 0);
    check("rst_mid.result", result, 0);
    check("rst_mid.hi", hi, 0);
    check("rst_mid.lo", lo, 0);
    #1;
    rst_n = 1'b1;
    m_hi = '0; m_lo = '0;
    run_op("rst_add", 4'h2, 32'd5, 32'd6, 1'b0);
    check("rst_add.lit", result, 32'd11);

    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 15));
      run_op($sformatf("rnd%0d", i), op, pick(), pick(),
             ((op == 4'h4) || (op == 4'hD)) && ($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_md.md
ALU_MD -- requirements
Module: alu_md

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (legal values 8..64, even).
REQ-002 SHALL have parameter SHW, default $clog2(WIDTH), shift-amount width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operation request.
REQ-006 SHALL have port in_ready  output  1  high when a request can be accepted.
REQ-007 SHALL have port ctrl  input  4  operation code.
REQ-008 SHALL have port in_0  input  WIDTH  operand A; shift amount for shifts.
REQ-009 SHALL have port in_1  input  WIDTH  operand B; value shifted for shifts.
REQ-010 SHALL have port out_valid  output  1  one-cycle pulse marking a completed operation.
REQ-011 SHALL have port result  output  WIDTH  primary result.
REQ-012 SHALL have port hi  output  WIDTH  high product half or remainder.
REQ-013 SHALL have port lo  output  WIDTH  low product half or quotient.
REQ-014 SHALL have port busy  output  1  high while a multi-cycle operation is in progress.

Function
REQ-015 SHALL accept a request on a rising edge with in_valid=1 and in_ready=1; in_ready=1 only in state IDLE.
REQ-016 SHALL decode single-cycle ops: 0000 and, 0001 or, 0010 add, 0011/0110 sub, 0111 signed slt (result 1/0), 1000 nor, 1001 xor, 1010 sll, 1011 sra, 1100 srl; all arithmetic is modulo 2^WIDTH.
REQ-017 SHALL take the shift amount from in_0[SHW-1:0] only and shift in_1.
REQ-018 SHALL decode multi-cycle ops: 0100 multu, 1101 mult (signed), 0101 divu, 1110 div (signed); code 1111 SHALL complete as a single-cycle op with result 0.
REQ-019 SHALL register single-cycle results: request accepted at edge N gives out_valid=1 and a valid result during the cycle after edge N; hi and lo are unchanged.
REQ-020 SHALL implement the FSM IDLE -> MUL or DIV (WIDTH cycles, 1 bit per cycle) -> DONE (1 cycle, out_valid=1) -> IDLE; busy=1 in MUL, DIV and DONE.
REQ-021 SHALL signal multi-cycle completion with out_valid exactly WIDTH+1 edges after the accepting edge.
REQ-022 SHALL compute a multiply as a 2*WIDTH product: {hi,lo}=product, result=lo; signed ops use magnitude arithmetic with the sign fixed at the end.
REQ-023 SHALL compute a divide as lo=quotient, hi=remainder, result=quotient; signed quotient is truncated toward zero, and the remainder takes the dividend's sign.
REQ-024 SHALL handle divide by zero as lo=all-ones, hi=dividend (as given), result=all-ones, with normal latency.
REQ-025 SHALL handle signed overflow (MIN / -1) as lo=MIN, hi=0.
REQ-026 SHALL ignore in_valid while in_ready=0 and capture operands only at acceptance; later operand changes have no effect.
REQ-027 SHALL hold result, hi and lo stable between completions.
REQ-028 SHALL pulse out_valid for exactly one cycle per accepted request.

Reset
REQ-029 SHALL on rst_n=0 asynchronously force state IDLE, out_valid=0, busy=0, result=0, hi=0, lo=0 and all internal counters and registers to 0.
REQ-030 SHALL abort any in-flight operation on reset mid-operation with no out_valid; in_ready=1 on the first cycle after rst_n deasserts.

Configuration
REQ-031 SHALL, with ALU_MD_DIV_EN defined, implement divu and div per REQ-020..REQ-025.
REQ-032 SHALL, without ALU_MD_DIV_EN, remove the divider logic; codes 0101 and 1110 then complete as single-cycle ops with result=0, hi=0, lo=0.

Verification (WIDTH=32)
REQ-033 SHALL cover: add 0x7FFFFFFF+1 -> result=0x80000000, out_valid 1 cycle after accept; slt -1,1 -> result=1.
REQ-034 SHALL cover: sra in_0=36 (shift 4), in_1=0x80000000 -> result=0xF8000000.
REQ-035 SHALL cover: mult -3 x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB, out_valid exactly 33 edges after accept, in_ready=0 throughout.
REQ-036 SHALL cover: div -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 5/0 -> lo=0xFFFFFFFF, hi=5.
REQ-037 SHALL cover: multu issued, rst_n pulsed low at cycle 10 -> no out_valid, all outputs 0, new add accepted the next cycle.
REQ-038 SHALL cover: in_valid held high with changing operands during a mult -> only the first request completes, with the original operands.
